// File: rtl/sort_stream_bridge.sv
// Stream-to-sorter bridge: collects N words, hands them to an external sorter,
// then streams the sorted frame back out with ready/valid and an end-of-frame marker.
module sort_stream_bridge #(
    parameter int N       = 6,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             sort_start,
    output logic [WIDTH-1:0] sort_data [N],
    input  logic             sort_done,
    input  logic [WIDTH-1:0] sort_result [N],
    output logic             timeout_err,
    output logic [15:0]      frame_cnt
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {FILL, KICK, WAIT, DRAIN} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] frame_buf [N];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [CNT_W-1:0] wait_cnt;

    // The sorter reads the frame straight out of the buffer, which only changes in FILL or on capture.
    assign sort_data = frame_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (s_valid && wr_idx == LAST_IDX) state_next = KICK;
            KICK:    state_next = WAIT;
            // A completion arriving on the final wait cycle still wins over the abort.
            WAIT: begin
                if (sort_done) begin
                    state_next = DRAIN;
                end else if (wait_cnt == LAST_WAIT) begin
                    state_next = FILL;
                end
            end
            DRAIN:   if (m_ready && rd_idx == LAST_IDX) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        case (state)
            FILL:    s_ready = !rst;
            DRAIN: begin
                m_valid = 1'b1;
                m_data  = frame_buf[rd_idx];
                m_last  = (rd_idx == LAST_IDX);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                frame_buf[i] <= '0;
            end
            wr_idx      <= '0;
            rd_idx      <= '0;
            wait_cnt    <= '0;
            frame_cnt   <= '0;
            timeout_err <= 1'b0;
            sort_start  <= 1'b0;
        end else begin
            // Registered so the pulse lines up exactly with the single KICK cycle.
            sort_start <= (state_next == KICK);
            case (state)
                FILL: begin
                    if (s_valid) begin
                        frame_buf[wr_idx] <= s_data;
                        wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IDX_W'(1);
                    end
                end
                KICK: wait_cnt <= '0;
                WAIT: begin
                    if (sort_done) begin
                        for (int i = 0; i < N; i++) begin
                            frame_buf[i] <= sort_result[i];
                        end
                        wait_cnt <= '0;
                    end else if (wait_cnt == LAST_WAIT) begin
                        timeout_err <= 1'b1;
                        wait_cnt    <= '0;
                        wr_idx      <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (rd_idx == LAST_IDX) begin
                            rd_idx    <= '0;
                            frame_cnt <= frame_cnt + 16'd1;
                        end else begin
                            rd_idx <= rd_idx + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
